vector_regfile_wb: RTL and testbench
====================================

Name: vector_regfile_wb

Overview:
- Writeback-side consumer of the MEM/WB pipeline register in the vector processor.
- Selects the writeback result: memory data or ALU result, per MemtoReg.
- Commits the result to a 16-entry vector register file of 8 lanes x N bits.
- Provides two read ports with same-cycle write bypass, plus a pending-write scoreboard used by decode/issue for hazard detection.

Parameters:
- N, 20, lane width in bits.
- LANES, 8, lanes per vector register.
- REGS, 16, number of vector registers; address width is log2(REGS) = 4.

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  asynchronous, active-low reset.
- wb_regwrite  in  1  writeback enable, from the RegWrite output of the WB pipeline register.
- wb_memtoreg  in  1  1 = write memory data, 0 = write ALU result.
- wb_wa3  in  4  destination register address.
- wb_memdata  in  [LANES-1:0][N-1:0]  memory read data.
- wb_aluout  in  [LANES-1:0][N-1:0]  ALU result.
- wb_result  out  [LANES-1:0][N-1:0]  selected writeback value (combinational); also drives forwarding.
- ra1  in  4  read address, port 1.
- ra2  in  4  read address, port 2.
- rd1  out  [LANES-1:0][N-1:0]  read data, port 1.
- rd2  out  [LANES-1:0][N-1:0]  read data, port 2.
- busy1  out  1  register at ra1 has an outstanding write not yet available.
- busy2  out  1  register at ra2 has an outstanding write not yet available.
- sb_set  in  1  issue stage marks a destination as pending.
- sb_wa  in  4  destination address being marked.
- pending  out  REGS  scoreboard vector; bit i = register i awaits writeback.

Behaviour:
- Reset (reset=0, asynchronous): all REGS x LANES entries clear to 0; pending clears to 0.
  - Takes effect immediately, including mid-operation; in-flight writes are lost.
  - Release is sampled synchronously at the next posedge.
- Result select: wb_result = wb_memtoreg ? wb_memdata : wb_aluout, all lanes together.
- Write: on posedge, if wb_regwrite=1, regs[wb_wa3] <= wb_result (all lanes).
  - wb_regwrite=0 means no write, regardless of wb_memtoreg or data.
  - Register 0 is an ordinary writable register.
- Read (combinational, 0-cycle latency):
  - rdX = wb_result if wb_regwrite=1 and raX==wb_wa3 (write-first bypass).
  - Otherwise rdX = regs[raX].
  - Both ports may address the same register; both may bypass in the same cycle.
- Scoreboard (per register, evaluated on posedge):
  - Clear pending[wb_wa3] when wb_regwrite=1.
  - Set pending[sb_wa] when sb_set=1.
  - Set and clear on the same address in the same cycle: bit ends SET (new producer wins).
  - Set and clear on different addresses in the same cycle: both apply.
  - Setting an already-set bit leaves it set; clearing an already-clear bit leaves it clear.
- Busy: busyX = pending[raX] & ~(wb_regwrite & (wb_wa3==raX)).
  - The bypass covers the retiring write, so no extra stall cycle is needed.
- No arithmetic: data passes through bit-exact, with no width change or truncation.

Test Plan:
- Reset check: drive reset=0 mid-simulation, asynchronous to clk -> pending=0 at once; after release, ra1=0..15 give rd1=0 and busy1=0.
- ALU writeback: wb_regwrite=1, wb_memtoreg=0, wb_wa3=5, aluout lanes = 20'h00001..20'h00008, memdata = 20'hFFFFF.
  - Same cycle with ra1=5: rd1 = 1..8 (bypass).
  - Next cycle with wb_regwrite=0: rd1 still = 1..8.
- Memory writeback: wb_memtoreg=1, wb_wa3=15, memdata all lanes = 20'hABCDE -> rd2 at ra2=15 = 20'hABCDE on every lane.
  - A second cycle with wb_regwrite=0, wb_wa3=15, new data -> register 15 unchanged.
- Scoreboard hazard: sb_set=1, sb_wa=3 -> next cycle pending=16'h0008 and busy1=1 at ra1=3.
  - Then wb_regwrite=1, wb_wa3=3 -> busy1=0 in that cycle, rd1 = wb_result, and pending=0 after the edge.
- Simultaneous events:
  - sb_set at 7 with wb_regwrite at 7 in one cycle -> pending[7]=1 after the edge.
  - sb_set at 2 with wb_regwrite at 9 (pending[9] previously 1) -> pending[2]=1 and pending[9]=0.
- Dual read: ra1=ra2=5 while writing register 5 -> rd1=rd2=wb_result; ra1=4, ra2=5 -> rd1 = stored value of register 4, rd2 bypassed.

Source files
------------

// File: rtl/vector_regfile_wb.sv
// Writeback result select, 16 x 8-lane vector register file, and pending-write scoreboard.
// Latency: result, reads, bypass and busy are combinational; writes and scoreboard update on posedge.
// Backpressure: none; every writeback is accepted, and busy flags let issue stall on pending registers.
module vector_regfile_wb #(
    parameter int N     = 20,
    parameter int LANES = 8,
    parameter int REGS  = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          wb_regwrite,
    input  logic                          wb_memtoreg,
    input  logic [$clog2(REGS)-1:0]       wb_wa3,
    input  logic [LANES-1:0][N-1:0]       wb_memdata,
    input  logic [LANES-1:0][N-1:0]       wb_aluout,
    output logic [LANES-1:0][N-1:0]       wb_result,
    input  logic [$clog2(REGS)-1:0]       ra1,
    input  logic [$clog2(REGS)-1:0]       ra2,
    output logic [LANES-1:0][N-1:0]       rd1,
    output logic [LANES-1:0][N-1:0]       rd2,
    output logic                          busy1,
    output logic                          busy2,
    input  logic                          sb_set,
    input  logic [$clog2(REGS)-1:0]       sb_wa,
    output logic [REGS-1:0]               pending
);

    logic [LANES-1:0][N-1:0] regs [REGS];
    logic [REGS-1:0]         pending_nxt;
    logic                    hit1;
    logic                    hit2;

    assign wb_result = wb_memtoreg ? wb_memdata : wb_aluout;

    // Write-first bypass: a retiring write is visible to readers in its own cycle.
    assign hit1 = wb_regwrite && (ra1 == wb_wa3);
    assign hit2 = wb_regwrite && (ra2 == wb_wa3);

    assign rd1 = hit1 ? wb_result : regs[ra1];
    assign rd2 = hit2 ? wb_result : regs[ra2];

    assign busy1 = pending[ra1] & ~hit1;
    assign busy2 = pending[ra2] & ~hit2;

    // Set is applied after clear so a new producer on the retiring register wins.
    always_comb begin
        pending_nxt = pending;
        if (wb_regwrite) begin
            pending_nxt[wb_wa3] = 1'b0;
        end
        if (sb_set) begin
            pending_nxt[sb_wa] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < REGS; i++) begin
                regs[i] <= '0;
            end
            pending <= '0;
        end else begin
            if (wb_regwrite) begin
                regs[wb_wa3] <= wb_result;
            end
            pending <= pending_nxt;
        end
    end

endmodule

// File: tb/tb_vector_regfile_wb.sv
// Directed and randomized bench for vector_regfile_wb against an array-based reference model.
module tb_vector_regfile_wb;

    localparam int N     = 20;
    localparam int LANES = 8;
    localparam int REGS  = 16;

    typedef logic [LANES-1:0][N-1:0] vec_t;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic            wb_regwrite = 1'b0;
    logic            wb_memtoreg = 1'b0;
    logic [3:0]      wb_wa3 = '0;
    vec_t            wb_memdata = '0;
    vec_t            wb_aluout = '0;
    vec_t            wb_result;
    logic [3:0]      ra1 = '0;
    logic [3:0]      ra2 = '0;
    vec_t            rd1;
    vec_t            rd2;
    logic            busy1;
    logic            busy2;
    logic            sb_set = 1'b0;
    logic [3:0]      sb_wa = '0;
    logic [REGS-1:0] pending;

    vector_regfile_wb #(.N(N), .LANES(LANES), .REGS(REGS)) dut (
        .clk(clk), .reset(reset),
        .wb_regwrite(wb_regwrite), .wb_memtoreg(wb_memtoreg), .wb_wa3(wb_wa3),
        .wb_memdata(wb_memdata), .wb_aluout(wb_aluout), .wb_result(wb_result),
        .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2), .busy1(busy1), .busy2(busy2),
        .sb_set(sb_set), .sb_wa(sb_wa), .pending(pending)
    );

    always #5 clk = ~clk;

    // Reference model: register contents and the set of registers awaiting writeback.
    vec_t            m_regs [REGS];
    logic [REGS-1:0] m_pend;

    int checks = 0;
    int failures = 0;

    task automatic chk_vec(input string tag, input vec_t obs, input vec_t exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_bit(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_pend(input string tag, input logic [REGS-1:0] obs, input logic [REGS-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic vec_t rand_vec();
        vec_t v;
        for (int l = 0; l < LANES; l++) v[l] = N'($urandom);
        return v;
    endfunction

    function automatic vec_t exp_result();
        return wb_memtoreg ? wb_memdata : wb_aluout;
    endfunction

    // Compare every output against what the model says the current inputs should produce.
    task automatic check_outputs(input string tag);
        vec_t r;
        r = exp_result();
        chk_vec({tag, "/result"}, wb_result, r);
        chk_vec({tag, "/rd1"}, rd1, (wb_regwrite && ra1 == wb_wa3) ? r : m_regs[ra1]);
        chk_vec({tag, "/rd2"}, rd2, (wb_regwrite && ra2 == wb_wa3) ? r : m_regs[ra2]);
        chk_bit({tag, "/busy1"}, busy1, m_pend[ra1] && !(wb_regwrite && wb_wa3 == ra1));
        chk_bit({tag, "/busy2"}, busy2, m_pend[ra2] && !(wb_regwrite && wb_wa3 == ra2));
        chk_pend({tag, "/pending"}, pending, m_pend);
    endtask

    // Advance one clock: the model absorbs the inputs present at the edge; returns at negedge.
    task automatic tick();
        vec_t       r;
        logic       we;
        logic       st;
        logic [3:0] wa;
        logic [3:0] sa;
        r  = exp_result();
        we = wb_regwrite;
        st = sb_set;
        wa = wb_wa3;
        sa = sb_wa;
        @(posedge clk);
        if (reset) begin
            if (we) begin
                m_regs[wa] = r;
                m_pend[wa] = 1'b0;
            end
            if (st) m_pend[sa] = 1'b1;
        end
        @(negedge clk);
    endtask

    task automatic model_clear();
        for (int i = 0; i < REGS; i++) m_regs[i] = '0;
        m_pend = '0;
    endtask

    task automatic idle();
        wb_regwrite = 1'b0;
        wb_memtoreg = 1'b0;
        sb_set = 1'b0;
    endtask

    vec_t alu_pat;
    vec_t ffff_pat;
    vec_t abcde_pat;

    initial begin
        model_clear();
        for (int l = 0; l < LANES; l++) begin
            alu_pat[l]   = N'(l + 1);
            ffff_pat[l]  = 20'hFFFFF;
            abcde_pat[l] = 20'hABCDE;
        end

        // Power-on reset, released at a negedge so the next posedge samples it.
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk_pend("por_pending", pending, '0);
        check_outputs("por");

        // ALU writeback to register 5 with same-cycle bypass.
        wb_regwrite = 1'b1; wb_memtoreg = 1'b0; wb_wa3 = 4'd5;
        wb_aluout = alu_pat; wb_memdata = ffff_pat; ra1 = 4'd5; ra2 = 4'd0;
        #1;
        chk_vec("alu_bypass", rd1, alu_pat);
        check_outputs("alu_wb");
        tick();
        wb_regwrite = 1'b0;
        #1;
        chk_vec("alu_stored", rd1, alu_pat);
        check_outputs("alu_hold");

        // Memory writeback to register 15, then a disabled write must not disturb it.
        wb_regwrite = 1'b1; wb_memtoreg = 1'b1; wb_wa3 = 4'd15;
        wb_memdata = abcde_pat; wb_aluout = rand_vec(); ra2 = 4'd15;
        #1;
        chk_vec("mem_bypass", rd2, abcde_pat);
        tick();
        wb_regwrite = 1'b0; wb_memdata = rand_vec(); wb_aluout = rand_vec();
        #1;
        chk_vec("mem_nowrite_same", rd2, abcde_pat);
        tick();
        #1;
        chk_vec("mem_nowrite_after", rd2, abcde_pat);
        check_outputs("mem_hold");

        // Scoreboard hazard on register 3, cleared by its writeback.
        idle();
        sb_set = 1'b1; sb_wa = 4'd3;
        tick();
        sb_set = 1'b0; ra1 = 4'd3;
        #1;
        chk_pend("sb_set3", pending, 16'h0008);
        chk_bit("sb_busy3", busy1, 1'b1);
        wb_regwrite = 1'b1; wb_memtoreg = 1'b0; wb_wa3 = 4'd3; wb_aluout = rand_vec();
        #1;
        chk_bit("sb_retire_busy", busy1, 1'b0);
        chk_vec("sb_retire_rd1", rd1, wb_aluout);
        tick();
        idle();
        #1;
        chk_pend("sb_cleared", pending, 16'h0000);

        // Simultaneous set/clear: same address keeps the bit, different addresses both apply.
        sb_set = 1'b1; sb_wa = 4'd9;
        tick();
        sb_set = 1'b1; sb_wa = 4'd7;
        wb_regwrite = 1'b1; wb_wa3 = 4'd7; wb_aluout = rand_vec();
        tick();
        #1;
        chk_pend("sim_same", pending, 16'h0280);
        sb_set = 1'b1; sb_wa = 4'd2;
        wb_regwrite = 1'b1; wb_wa3 = 4'd9; wb_aluout = rand_vec();
        tick();
        idle();
        #1;
        chk_pend("sim_diff", pending, 16'h0084);

        // Dual read of one register, then split ports with only one bypassing.
        wb_regwrite = 1'b1; wb_memtoreg = 1'b0; wb_wa3 = 4'd4; wb_aluout = rand_vec();
        tick();
        wb_regwrite = 1'b1; wb_wa3 = 4'd5; wb_aluout = rand_vec(); ra1 = 4'd5; ra2 = 4'd5;
        #1;
        chk_vec("dual_rd1", rd1, wb_aluout);
        chk_vec("dual_rd2", rd2, wb_aluout);
        ra1 = 4'd4;
        #1;
        chk_vec("split_rd1", rd1, m_regs[4]);
        chk_vec("split_rd2", rd2, wb_aluout);
        check_outputs("split");
        tick();

        // Randomized traffic against the model.
        for (int c = 0; c < 400; c++) begin
            wb_regwrite = 1'($urandom);
            wb_memtoreg = 1'($urandom);
            wb_wa3      = 4'($urandom);
            wb_memdata  = rand_vec();
            wb_aluout   = rand_vec();
            ra1         = 4'($urandom);
            ra2         = (c % 4 == 0) ? wb_wa3 : 4'($urandom);
            sb_set      = ($urandom_range(0, 2) == 0);
            sb_wa       = (c % 8 == 0) ? wb_wa3 : 4'($urandom);
            #1;
            check_outputs("rand");
            tick();
        end

        // Asynchronous reset mid-cycle with a pending bit and stored data present.
        idle();
        sb_set = 1'b1; sb_wa = 4'd11;
        wb_regwrite = 1'b1; wb_wa3 = 4'd12; wb_aluout = rand_vec();
        tick();
        idle();
        ra1 = 4'd12; ra2 = 4'd11;
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        model_clear();
        chk_pend("async_rst_pending", pending, '0);
        chk_vec("async_rst_rd1", rd1, '0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        for (int r = 0; r < REGS; r++) begin
            ra1 = 4'(r);
            #1;
            chk_vec("post_rst_rd1", rd1, '0);
            chk_bit("post_rst_busy1", busy1, 1'b0);
        end
        tick();
        #1;
        check_outputs("post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
